fnd_scan_controller: RTL and testbench
======================================

// Module: fnd_scan_controller
// PURPOSE
//   Parametrised time-multiplexed driver for an N-digit common-anode 7-seg (FND) display.
//   Shows a packed hex word, one nibble per digit.
//   Adds per-digit decimal points, leading-zero suppression, PWM brightness and anti-ghost blanking.
//   Display data is double-buffered so digits never tear mid-frame.
//   Sits between any value producer (e.g. IR decoder data word) and the board FND pins.
// PARAMETERS
//   DIGITS        4       number of digits / com lines (2..8)
//   SCAN_CYCLES   100000  clk cycles each digit is selected (dwell), >= BLANK_CYCLES+2^BRIGHT_W
//   BLANK_CYCLES  1000    cycles at start of each dwell with all com inactive (anti-ghost)
//   BRIGHT_W      4       brightness code width
// PORTS
//   clk          in   1           system clock
//   reset_n      in   1           synchronous, active-low reset
//   enable       in   1           1 = scan display; 0 = display dark
//   update       in   1           1-cycle strobe: capture value/dp_mask/lz_en into pending buffer
//   value        in   4*DIGITS    hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost
//   dp_mask      in   DIGITS      1 = decimal point lit on digit k
//   lz_en        in   1           1 = suppress leading zeros
//   brightness   in   BRIGHT_W    PWM duty code; all-ones = full on
//   com          out  DIGITS      digit select, active-low, at most one bit low
//   seg_7        out  8           {a,b,c,d,e,f,g,dp}, active-low, [7]=a .. [0]=dp
//   frame_done   out  1           1-cycle pulse on last cycle of digit DIGITS-1 dwell
// BEHAVIOUR
//   - Reset (reset_n=0 at clk edge)
//     - com=all 1, seg_7=8'hFF, frame_done=0.
//     - Digit index=0, dwell/PWM counters=0.
//     - Display and pending buffers=0, pending_valid=0, FSM=IDLE.
//     - Reset wins over all other inputs; mid-frame reset gives these values at the next edge.
//   - FSM
//     - IDLE: enable=0 forces IDLE; outputs dark.
//     - IDLE -> BLANK on enable=1, starting at digit 0, dwell counter t=0.
//     - BLANK: t < BLANK_CYCLES, com all 1.
//     - SHOW: BLANK_CYCLES <= t < SCAN_CYCLES.
//     - At t=SCAN_CYCLES-1: t->0, state->BLANK, digit index +1, wrapping DIGITS-1 -> 0.
//     - enable=0 in any state -> IDLE next cycle, outputs dark.
//   - PWM
//     - BRIGHT_W-bit pwm counter cleared on entering SHOW, then free-running.
//     - com[idx] low only when state=SHOW and pwm <= brightness.
//     - brightness=0 gives 1/2^BRIGHT_W duty; all-ones gives 100% duty.
//   - Glyphs (0-F)
//     - 0=0000_0011, 1=1001_1111, 2=0010_0101, 3=0000_1101
//     - 4=1001_1001, 5=0100_1001, 6=0100_0001, 7=0001_1111
//     - 8=0000_0001, 9=0001_1001, A=0001_0001, b=1100_0001
//     - C=0110_0011, d=1000_0101, E=0110_0001, F=0111_0001
//     - dp_mask[idx]=1 clears seg_7[0].
//   - Leading-zero suppression (lz_en=1)
//     - Digit k is blank (segments a..g all 1) if every nibble k..DIGITS-1 is 0 and k != 0.
//     - Digit 0 is never suppressed.
//     - DP still obeys dp_mask on a suppressed digit.
//   - Buffering
//     - update=1 loads the pending buffer and sets pending_valid.
//     - On the frame_done cycle, if pending_valid, display <= pending and pending_valid <= 0.
//     - update on the same cycle as frame_done: the incoming inputs go straight to display.
//     - brightness is not buffered; it applies immediately.
//   - Latency: com/seg_7 are registered, 1 cycle behind internal state/index.
//   - frame_done: pulses even when no pending data; never asserted in IDLE.
// TESTING  (DIGITS=4, SCAN_CYCLES=16, BLANK_CYCLES=2, BRIGHT_W=2)
//   1 Reset: reset_n=0 for 3 clk while enable=1
//     -> com=4'b1111, seg_7=8'hFF, frame_done=0 throughout.
//   2 Scan: update value=16'h1234, dp_mask=0, brightness=3, enable=1; wait first frame_done
//     -> next frame com 1110/1101/1011/0111 show 4,3,2,1 glyphs;
//     -> 2 dark cycles per digit; frame_done period=64 clk.
//   3 LZ: value=16'h0050, lz_en=1, dp_mask=4'b0100
//     -> digit0=0, digit1=5, digit2 seg_7=8'hFE, digit3 seg_7=8'hFF;
//     -> value=0 gives only digit0 showing '0'.
//   4 PWM: brightness=0
//     -> during SHOW, com[idx] low exactly 1 of every 4 cycles (first cycle of SHOW);
//     -> brightness=2 gives 3 of 4.
//   5 Double buffer: update 16'hABCD mid-frame while showing 16'h1234
//     -> digits keep 1234 until frame_done, ABCD from next frame;
//     -> update coincident with frame_done applies at that boundary.
//   6 enable=0 mid-SHOW then 1
//     -> dark from next cycle;
//     -> restart at digit 0 with BLANK, display buffer contents retained.

Source files
------------

// File: rtl/fnd_scan_if.sv
// Display-side bundle for fnd_scan_controller: value producer inputs and FND pin outputs.
interface fnd_scan_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic                  enable;
  logic                  update;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic                  lz_en;
  logic [BRIGHT_W-1:0]   brightness;
  logic [DIGITS-1:0]     com;
  logic [7:0]            seg_7;
  logic                  frame_done;

  modport master (
    output enable, update, value, dp_mask, lz_en, brightness,
    input  com, seg_7, frame_done
  );

  modport slave (
    input  enable, update, value, dp_mask, lz_en, brightness,
    output com, seg_7, frame_done
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed common-anode 7-seg driver with double-buffered data,
// leading-zero suppression, PWM brightness and per-dwell anti-ghost blanking.
module fnd_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int SCAN_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BRIGHT_W     = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  fnd_scan_if.slave bus
);

  localparam int T_W   = $clog2(SCAN_CYCLES);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [T_W-1:0]   T_LAST     = T_W'(SCAN_CYCLES - 1);
  localparam logic [T_W-1:0]   T_PRE_LAST = T_W'(SCAN_CYCLES - 2);
  localparam logic [T_W-1:0]   T_SHOW     = T_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam state_t DWELL_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t              state_reg;
  logic [T_W-1:0]      t_reg;
  logic [T_W-1:0]      t_inc;
  logic [IDX_W-1:0]    idx_reg;
  logic [BRIGHT_W-1:0] pwm_reg;
  logic [DIGITS-1:0]   com_reg;
  logic [DIGITS-1:0]   com_next;
  logic [7:0]          seg_reg;
  logic [7:0]          seg_next;
  logic                frame_done_reg;

  logic [4*DIGITS-1:0] disp_value_reg;
  logic [DIGITS-1:0]   disp_dp_reg;
  logic                disp_lz_reg;
  logic [4*DIGITS-1:0] pend_value_reg;
  logic [DIGITS-1:0]   pend_dp_reg;
  logic                pend_lz_reg;
  logic                pend_valid_reg;

  logic [7:0]          glyph_dig [DIGITS];

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'b0000_0011;
      4'h1: g = 8'b1001_1111;
      4'h2: g = 8'b0010_0101;
      4'h3: g = 8'b0000_1101;
      4'h4: g = 8'b1001_1001;
      4'h5: g = 8'b0100_1001;
      4'h6: g = 8'b0100_0001;
      4'h7: g = 8'b0001_1111;
      4'h8: g = 8'b0000_0001;
      4'h9: g = 8'b0001_1001;
      4'hA: g = 8'b0001_0001;
      4'hB: g = 8'b1100_0001;
      4'hC: g = 8'b0110_0011;
      4'hD: g = 8'b1000_0101;
      4'hE: g = 8'b0110_0001;
      default: g = 8'b0111_0001;
    endcase
    return g;
  endfunction

  // Per-digit segment pattern; a digit is a leading zero when it and every higher nibble are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [7:0] raw_glyph;
    logic       suppress;
    assign raw_glyph = hex_glyph(disp_value_reg[4*gi +: 4]);
    if (gi == 0) begin : g_lsd
      assign suppress = 1'b0;
    end else begin : g_upper
      assign suppress = disp_lz_reg && (disp_value_reg[4*DIGITS-1:4*gi] == '0);
    end
    assign glyph_dig[gi] = {(suppress ? 7'h7F : raw_glyph[7:1]), ~disp_dp_reg[gi]};
  end

  assign t_inc = t_reg + T_W'(1);

  always_comb begin
    com_next = '1;
    seg_next = 8'hFF;
    if (state_reg == SHOW) begin
      seg_next = glyph_dig[idx_reg];
      if (pwm_reg <= bus.brightness) begin
        com_next[idx_reg] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !bus.enable) begin
      state_reg      <= IDLE;
      t_reg          <= '0;
      idx_reg        <= '0;
      pwm_reg        <= '0;
      com_reg        <= '1;
      seg_reg        <= 8'hFF;
      frame_done_reg <= 1'b0;
    end else begin
      com_reg        <= com_next;
      seg_reg        <= seg_next;
      // Registered so the pulse lands exactly on the last internal cycle of the frame.
      frame_done_reg <= (state_reg != IDLE) && (idx_reg == IDX_LAST) && (t_reg == T_PRE_LAST);
      case (state_reg)
        IDLE: begin
          state_reg <= DWELL_START;
          t_reg     <= '0;
          idx_reg   <= '0;
          pwm_reg   <= '0;
        end
        default: begin
          if (t_reg == T_LAST) begin
            t_reg     <= '0;
            idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            state_reg <= DWELL_START;
            pwm_reg   <= '0;
          end else begin
            t_reg <= t_inc;
            if (t_inc == T_SHOW) begin
              state_reg <= SHOW;
              pwm_reg   <= '0;
            end else begin
              pwm_reg <= pwm_reg + BRIGHT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // An update coinciding with frame end bypasses the pending buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_value_reg <= '0;
      disp_dp_reg    <= '0;
      disp_lz_reg    <= 1'b0;
      pend_value_reg <= '0;
      pend_dp_reg    <= '0;
      pend_lz_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
    end else if (bus.update && frame_done_reg) begin
      disp_value_reg <= bus.value;
      disp_dp_reg    <= bus.dp_mask;
      disp_lz_reg    <= bus.lz_en;
      pend_valid_reg <= 1'b0;
    end else if (bus.update) begin
      pend_value_reg <= bus.value;
      pend_dp_reg    <= bus.dp_mask;
      pend_lz_reg    <= bus.lz_en;
      pend_valid_reg <= 1'b1;
    end else if (frame_done_reg && pend_valid_reg) begin
      disp_value_reg <= pend_value_reg;
      disp_dp_reg    <= pend_dp_reg;
      disp_lz_reg    <= pend_lz_reg;
      pend_valid_reg <= 1'b0;
    end
  end

  assign bus.com        = com_reg;
  assign bus.seg_7      = seg_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized bench for fnd_scan_controller against a frame-position reference model.
module tb_fnd_scan_controller;

  localparam int D     = 4;
  localparam int SCAN  = 16;
  localparam int BLANK = 2;
  localparam int BW    = 2;
  localparam int FRAME = D * SCAN;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fnd_scan_if #(.DIGITS(D), .BRIGHT_W(BW)) bus ();

  fnd_scan_controller #(
    .DIGITS(D), .SCAN_CYCLES(SCAN), .BLANK_CYCLES(BLANK), .BRIGHT_W(BW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tbl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int last_fd = -1;
  bit track_period = 0;

  // Model: position within the frame since the scan was (re)started.
  bit         m_active = 0;
  int         m_pos = 0;
  logic [15:0] m_disp_val = '0, m_pend_val = '0;
  logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
  logic        m_disp_lz = 0, m_pend_lz = 0, m_pend_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input int k);
    logic [15:0] upper;
    logic [7:0]  g;
    upper = m_disp_val >> (4 * k);
    if (m_disp_lz && k != 0 && upper == 0) g = 8'hFF;
    else g = glyph_tbl[upper[3:0]];
    if (m_disp_dp[k]) g[0] = 1'b0;
    return g;
  endfunction

  task automatic step();
    bit         fd_now;
    int         t, k, pwm;
    logic [3:0] c;
    logic [7:0] s;
    logic       e_fd;
    fd_now = m_active && (m_pos == FRAME - 1);
    c = '1;
    s = 8'hFF;
    if (reset_n && bus.enable && m_active) begin
      t = m_pos % SCAN;
      k = m_pos / SCAN;
      if (t >= BLANK) begin
        pwm = (t - BLANK) % (1 << BW);
        if (pwm <= int'(bus.brightness)) c[k] = 1'b0;
        s = model_seg(k);
      end
    end
    if (!reset_n) begin
      m_disp_val = '0; m_disp_dp = '0; m_disp_lz = 0;
      m_pend_val = '0; m_pend_dp = '0; m_pend_lz = 0; m_pend_valid = 0;
    end else if (bus.update && fd_now) begin
      m_disp_val = bus.value; m_disp_dp = bus.dp_mask; m_disp_lz = bus.lz_en; m_pend_valid = 0;
    end else if (bus.update) begin
      m_pend_val = bus.value; m_pend_dp = bus.dp_mask; m_pend_lz = bus.lz_en; m_pend_valid = 1;
    end else if (fd_now && m_pend_valid) begin
      m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_disp_lz = m_pend_lz; m_pend_valid = 0;
    end
    if (!reset_n || !bus.enable) begin
      m_active = 0; m_pos = 0;
    end else if (!m_active) begin
      m_active = 1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    e_fd = m_active && (m_pos == FRAME - 1);
    @(posedge clk);
    #1;
    cycle++;
    chk("com", 32'(bus.com), 32'(c));
    chk("seg_7", 32'(bus.seg_7), 32'(s));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    if (track_period && bus.frame_done) begin
      if (last_fd >= 0) chk("fd_period", 32'(cycle - last_fd), 32'(FRAME));
      last_fd = cycle;
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    bus.value = v; bus.dp_mask = dp; bus.lz_en = lz; bus.update = 1'b1;
    step();
    bus.update = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b1; bus.update = 1'b0; bus.value = '0; bus.dp_mask = '0;
    bus.lz_en = 1'b0; bus.brightness = 2'd3;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    // Basic scan and frame period
    load(16'h1234, 4'b0000, 1'b0);
    for (int i = 0; i < 200 && !bus.frame_done; i++) step();
    chk("first_fd_seen", 32'(bus.frame_done), 32'd1);
    track_period = 1;
    repeat (3 * FRAME) step();
    track_period = 0;

    // Leading-zero suppression
    load(16'h0050, 4'b0100, 1'b1);
    repeat (2 * FRAME) step();
    load(16'h0000, 4'b0000, 1'b1);
    repeat (2 * FRAME) step();

    // PWM duty
    load(16'h1234, 4'b0000, 1'b0);
    bus.brightness = 2'd0;
    repeat (2 * FRAME) step();
    bus.brightness = 2'd2;
    repeat (2 * FRAME) step();
    bus.brightness = 2'd3;

    // Double buffer: mid-frame update, then update coincident with frame end
    repeat (20) step();
    load(16'hABCD, 4'b0001, 1'b0);
    repeat (2 * FRAME) step();
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == FRAME - 1); i++) step();
    chk("coincident_aligned", 32'(m_pos), 32'(FRAME - 1));
    load(16'h5678, 4'b1000, 1'b0);
    repeat (FRAME + 8) step();

    // enable drop mid-SHOW
    for (int i = 0; i < 2 * SCAN && (m_pos % SCAN) != BLANK + 5; i++) step();
    bus.enable = 1'b0;
    repeat (10) step();
    bus.enable = 1'b1;
    repeat (2 * FRAME) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.update = ($urandom_range(0, 29) == 0);
      if (m_active && m_pos == FRAME - 1 && $urandom_range(0, 2) == 0) bus.update = 1'b1;
      if (bus.update) begin
        bus.value = 16'($urandom); bus.dp_mask = 4'($urandom); bus.lz_en = 1'($urandom);
      end
      if ($urandom_range(0, 49) == 0) bus.brightness = 2'($urandom);
      if (bus.enable) bus.enable = ($urandom_range(0, 299) != 0);
      else bus.enable = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 999) != 0);
      step();
    end
    bus.update = 1'b0;
    reset_n = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
